// File: rtl/rice_bit_packer.sv
// Rice codeword bit packer: serialises unary zero runs plus a right-aligned
// tail MSB-first into 16-bit words for the frame writer.
// Optional feature macro: RICE_PACKER_BITCOUNT_EN adds oBitCount, a running
// count of appended stream bits (padding excluded).
//
// state | meaning
// IDLE  | ready for a codeword, or executing a flush directly
// ZEROS | appending the unary zero run, up to one word's space per cycle
// TAIL  | appending tail bits MSB first, up to one word's space per cycle
// FLUSH | pad and emit the partial word after a deferred flush
module rice_bit_packer #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [WORD_WIDTH-1:0] iMSB,
  input  logic [WORD_WIDTH-1:0] iLSB,
  input  logic [WORD_WIDTH-1:0] iBitsUsed,
  input  logic                  iFlush,
  output logic [WORD_WIDTH-1:0] oData,
  output logic                  oValid,
  output logic                  oFlushDone
`ifdef RICE_PACKER_BITCOUNT_EN
  ,
  output logic [31:0]           oBitCount
`endif
);

  typedef enum logic [1:0] {IDLE, ZEROS, TAIL, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [15:0] zl, zl_nxt;
  logic [4:0]  tl, tl_nxt;
  logic [15:0] tail, tail_nxt;
  logic [15:0] wbuf, wbuf_nxt;
  logic [3:0]  fill, fill_nxt;
  logic        flush_pend, pend_nxt;
  logic [15:0] data_nxt;
  logic        valid_nxt, fdone_nxt;
  logic [4:0]  add_bits;

  logic [4:0]  space, n_zero, m_tail, shr, fill_sum;
  logic [16:0] mask, w_diff;
  logic [15:0] chunk, placed;
  logic [4:0]  tl_in;
  logic        pend_now;

  // Chunk sizing and tail extraction; space is never 0 because fill <= 15.
  always_comb begin
    space  = 5'd16 - {1'b0, fill};
    n_zero = (zl < {11'd0, space}) ? zl[4:0] : space;
    m_tail = (tl < space) ? tl : space;
    shr    = tl - m_tail;
    mask   = (17'd1 << m_tail) - 17'd1;
    chunk  = (tail >> shr) & mask[15:0];
    placed = chunk << (space - m_tail);
    w_diff = {1'b0, iBitsUsed} - {1'b0, iMSB};
    if (iBitsUsed < iMSB)       tl_in = 5'd0;
    else if (w_diff > 17'd16)   tl_in = 5'd16;
    else                        tl_in = w_diff[4:0];
    pend_now = flush_pend | iFlush;
  end

  assign oReady = iReset && (state == IDLE);

  // Next-state and datapath: appends, word completion and flush handling.
  always_comb begin
    state_nxt = state;
    zl_nxt    = zl;
    tl_nxt    = tl;
    tail_nxt  = tail;
    wbuf_nxt  = wbuf;
    fill_nxt  = fill;
    pend_nxt  = flush_pend;
    data_nxt  = oData;
    valid_nxt = 1'b0;
    fdone_nxt = 1'b0;
    add_bits  = 5'd0;
    fill_sum  = 5'd0;
    if (state != IDLE && iFlush) pend_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (iValid) begin
          zl_nxt   = iMSB;
          tl_nxt   = tl_in;
          tail_nxt = iLSB;
          pend_nxt = iFlush;
          if (iMSB != 16'd0)     state_nxt = ZEROS;
          else if (tl_in != 5'd0) state_nxt = TAIL;
          else if (iFlush)       state_nxt = FLUSH;
        end else if (iFlush) begin
          if (fill != 4'd0) begin
            data_nxt  = wbuf;
            valid_nxt = 1'b1;
            wbuf_nxt  = 16'd0;
            fill_nxt  = 4'd0;
          end
          fdone_nxt = 1'b1;
        end
      end
      ZEROS: begin
        // Zeros need no write: bits below the fill point are always clear.
        fill_sum = {1'b0, fill} + n_zero;
        add_bits = n_zero;
        if (fill_sum == 5'd16) begin
          data_nxt  = wbuf;
          valid_nxt = 1'b1;
          wbuf_nxt  = 16'd0;
          fill_nxt  = 4'd0;
        end else begin
          fill_nxt = fill_sum[3:0];
        end
        zl_nxt = zl - {11'd0, n_zero};
        if (zl == {11'd0, n_zero}) begin
          if (tl != 5'd0)    state_nxt = TAIL;
          else if (pend_now) state_nxt = FLUSH;
          else               state_nxt = IDLE;
        end
      end
      TAIL: begin
        fill_sum = {1'b0, fill} + m_tail;
        add_bits = m_tail;
        if (fill_sum == 5'd16) begin
          data_nxt  = wbuf | placed;
          valid_nxt = 1'b1;
          wbuf_nxt  = 16'd0;
          fill_nxt  = 4'd0;
        end else begin
          wbuf_nxt = wbuf | placed;
          fill_nxt = fill_sum[3:0];
        end
        tl_nxt = tl - m_tail;
        if (tl == m_tail) state_nxt = pend_now ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (fill != 4'd0) begin
          data_nxt  = wbuf;
          valid_nxt = 1'b1;
          wbuf_nxt  = 16'd0;
          fill_nxt  = 4'd0;
        end
        fdone_nxt = 1'b1;
        pend_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state      <= IDLE;
      zl         <= 16'd0;
      tl         <= 5'd0;
      tail       <= 16'd0;
      wbuf       <= 16'd0;
      fill       <= 4'd0;
      flush_pend <= 1'b0;
      oData      <= 16'd0;
      oValid     <= 1'b0;
      oFlushDone <= 1'b0;
    end else begin
      state      <= state_nxt;
      zl         <= zl_nxt;
      tl         <= tl_nxt;
      tail       <= tail_nxt;
      wbuf       <= wbuf_nxt;
      fill       <= fill_nxt;
      flush_pend <= pend_nxt;
      oData      <= data_nxt;
      oValid     <= valid_nxt;
      oFlushDone <= fdone_nxt;
    end
  end

`ifdef RICE_PACKER_BITCOUNT_EN
  // Running count of appended stream bits, wrapping at 2^32.
  always_ff @(posedge iClock) begin
    if (!iReset) oBitCount <= 32'd0;
    else         oBitCount <= oBitCount + {27'd0, add_bits};
  end
`endif

endmodule

// File: tb/tb_rice_bit_packer.sv
// Directed bench for rice_bit_packer: table of single-codeword cases plus
// hand-written multi-cycle sequences (streams, deferred flush, reset).
module tb_rice_bit_packer;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [15:0] iMSB = 16'd0;
  logic [15:0] iLSB = 16'd0;
  logic [15:0] iBitsUsed = 16'd0;
  logic        iFlush = 1'b0;
  logic [15:0] oData;
  logic        oValid;
  logic        oFlushDone;
`ifdef RICE_PACKER_BITCOUNT_EN
  logic [31:0] oBitCount;
`endif

  rice_bit_packer dut (
    .iClock(iClock), .iReset(iReset), .iValid(iValid), .oReady(oReady),
    .iMSB(iMSB), .iLSB(iLSB), .iBitsUsed(iBitsUsed), .iFlush(iFlush),
    .oData(oData), .oValid(oValid), .oFlushDone(oFlushDone)
`ifdef RICE_PACKER_BITCOUNT_EN
    , .oBitCount(oBitCount)
`endif
  );

  always #5 iClock = ~iClock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int last_acc = 0;
  logic in_rst = 1'b0;
  logic [15:0] wq[$];
  logic        fq[$];
  int          cq[$];

  always @(posedge iClock) begin
    cyc    <= cyc + 1;
    in_rst <= !iReset;
  end

  // Output monitor: collects words and flush pulses; oValid must stay low in reset.
  always @(negedge iClock) begin
    if (oValid) begin
      wq.push_back(oData);
      fq.push_back(oFlushDone);
      cq.push_back(cyc);
    end
    if (oFlushDone) fd_cnt++;
    if (in_rst) begin
      total++;
      if (oValid) begin
        bad++;
        $display("FAIL valid_in_reset: got oValid=1 required 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    wq.delete();
    fq.delete();
    cq.delete();
  endtask

  task automatic do_reset();
    @(negedge iClock);
    iReset = 1'b0; iValid = 1'b0; iFlush = 1'b0;
    repeat (2) @(negedge iClock);
    check("rst_ready", {31'd0, oReady}, 32'd0);
    check("rst_valid", {31'd0, oValid}, 32'd0);
    check("rst_data", {16'd0, oData}, 32'd0);
    iReset = 1'b1;
    @(negedge iClock);
    check("ready_after_rst", {31'd0, oReady}, 32'd1);
    clear_q();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!oReady && n < 200) begin
      @(negedge iClock);
      n++;
    end
    if (!oReady) begin
      total++; bad++;
      $display("FAIL ready_timeout: got oReady=0 required 1");
    end
  endtask

  task automatic send(input logic [15:0] msb, input logic [15:0] lsb,
                      input logic [15:0] bits, input logic fl);
    wait_ready();
    iValid = 1'b1; iMSB = msb; iLSB = lsb; iBitsUsed = bits; iFlush = fl;
    @(negedge iClock);
    last_acc = cyc;
    iValid = 1'b0; iFlush = 1'b0;
  endtask

  task automatic wait_fd(input int f0);
    int n = 0;
    while (fd_cnt == f0 && n < 200) begin
      @(negedge iClock);
      n++;
    end
    check("flush_done_count", fd_cnt - f0, 32'd1);
  endtask

  task automatic flush();
    int f0;
    wait_ready();
    f0 = fd_cnt;
    iFlush = 1'b1;
    @(negedge iClock);
    iFlush = 1'b0;
    wait_fd(f0);
  endtask

  typedef struct {
    logic [15:0] msb, lsb, bits;
    int          nw;
    logic [15:0] w0, w1;
    logic        fl;
    int          bc;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'd0,  16'h0016, 16'd5,  1, 16'hB000, 16'h0000, 1'b1, 5};
    vecs[1] = '{16'd20, 16'h0001, 16'd21, 2, 16'h0000, 16'h0800, 1'b1, 21};
    vecs[2] = '{16'd2,  16'hFFFF, 16'd40, 2, 16'h3FFF, 16'hC000, 1'b1, 18};
    vecs[3] = '{16'd3,  16'h0007, 16'd1,  1, 16'h0000, 16'h0000, 1'b1, 3};
    vecs[4] = '{16'd0,  16'hFFFF, 16'd0,  0, 16'h0000, 16'h0000, 1'b0, 0};
    vecs[5] = '{16'd1,  16'hFFF5, 16'd4,  1, 16'h5000, 16'h0000, 1'b1, 4};
    vecs[6] = '{16'd16, 16'h0003, 16'd18, 2, 16'h0000, 16'hC000, 1'b1, 18};
    vecs[7] = '{16'd0,  16'hABCD, 16'd16, 1, 16'hABCD, 16'h0000, 1'b0, 16};

    // Table: one codeword from reset, then flush.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      send(vecs[i].msb, vecs[i].lsb, vecs[i].bits, 1'b0);
      flush();
      repeat (2) @(negedge iClock);
      check($sformatf("v%0d_nwords", i), wq.size(), vecs[i].nw);
      if (wq.size() > 0 && vecs[i].nw > 0) check($sformatf("v%0d_w0", i), {16'd0, wq[0]}, {16'd0, vecs[i].w0});
      if (wq.size() > 1 && vecs[i].nw > 1) check($sformatf("v%0d_w1", i), {16'd0, wq[1]}, {16'd0, vecs[i].w1});
      if (wq.size() > 0 && vecs[i].nw > 0)
        check($sformatf("v%0d_fdone_with_last", i), {31'd0, fq[wq.size()-1]}, {31'd0, vecs[i].fl});
`ifdef RICE_PACKER_BITCOUNT_EN
      check($sformatf("v%0d_bitcount", i), oBitCount, vecs[i].bc);
`endif
    end

    // Sixteen single-one codewords form exactly one all-ones word.
    do_reset();
    for (int i = 0; i < 16; i++) send(16'd0, 16'd1, 16'd1, 1'b0);
    repeat (3) @(negedge iClock);
    check("ones_nwords", wq.size(), 32'd1);
    if (wq.size() > 0) begin
      check("ones_word", {16'd0, wq[0]}, 32'hFFFF);
      check("ones_latency", cq[0] - last_acc, 32'd1);
    end

    // Four 0001 codewords then a flush with nothing left to pad.
    do_reset();
    for (int i = 0; i < 4; i++) send(16'd3, 16'd1, 16'd4, 1'b0);
    flush();
    repeat (2) @(negedge iClock);
    check("nib_nwords", wq.size(), 32'd1);
    if (wq.size() > 0) begin
      check("nib_word", {16'd0, wq[0]}, 32'h1111);
      check("nib_word_no_fdone", {31'd0, fq[0]}, 32'd0);
    end

    // Long zero run: oReady low across the whole codeword.
    do_reset();
    send(16'd20, 16'd1, 16'd21, 1'b0);
    check("long_ready0", {31'd0, oReady}, 32'd0);
    @(negedge iClock);
    check("long_ready1", {31'd0, oReady}, 32'd0);
    @(negedge iClock);
    check("long_ready2", {31'd0, oReady}, 32'd0);
    @(negedge iClock);
    check("long_ready3", {31'd0, oReady}, 32'd1);

    // Flush raised mid-codeword is deferred until the codeword ends.
    do_reset();
    begin
      int f0;
      f0 = fd_cnt;
      send(16'd20, 16'd1, 16'd21, 1'b0);
      iFlush = 1'b1;
      @(negedge iClock);
      iFlush = 1'b0;
      wait_fd(f0);
    end
    repeat (2) @(negedge iClock);
    check("pend_nwords", wq.size(), 32'd2);
    if (wq.size() > 1) begin
      check("pend_w0", {16'd0, wq[0]}, 32'h0000);
      check("pend_w1", {16'd0, wq[1]}, 32'h0800);
      check("pend_fdone", {31'd0, fq[1]}, 32'd1);
    end

    // Flush together with a codeword: codeword first, then flush.
    do_reset();
    begin
      int f0;
      f0 = fd_cnt;
      send(16'd0, 16'h0016, 16'd5, 1'b1);
      wait_fd(f0);
    end
    repeat (2) @(negedge iClock);
    check("both_nwords", wq.size(), 32'd1);
    if (wq.size() > 0) begin
      check("both_word", {16'd0, wq[0]}, 32'hB000);
      check("both_fdone", {31'd0, fq[0]}, 32'd1);
    end

    // Reset during a long zero run abandons everything.
    do_reset();
    send(16'd40, 16'd0, 16'd40, 1'b0);
    iReset = 1'b0;
    repeat (2) @(negedge iClock);
    check("midrst_ready", {31'd0, oReady}, 32'd0);
    iReset = 1'b1;
    @(negedge iClock);
    check("midrst_ready_after", {31'd0, oReady}, 32'd1);
    repeat (10) @(negedge iClock);
    check("midrst_nwords", wq.size(), 32'd0);
    clear_q();
    for (int i = 0; i < 16; i++) send(16'd0, 16'd1, 16'd1, 1'b0);
    repeat (3) @(negedge iClock);
    check("midrst_after_nwords", wq.size(), 32'd1);
    if (wq.size() > 0) check("midrst_after_word", {16'd0, wq[0]}, 32'hFFFF);
`ifdef RICE_PACKER_BITCOUNT_EN
    check("midrst_bitcount", oBitCount, 32'd16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
